// File: rtl/md_pkg.sv
// Shared types for the multiply/divide unit.
//   md_op_t    : operation code driven by the main decoder / ALU control
//   md_state_t : controller state of muldiv_unit
//   MD_ITERS   : radix-2 iteration count (one bit per cycle, 32-bit datapath)
//   md_abs     : two's-complement magnitude, read as unsigned
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } md_state_t;

    localparam int MD_ITERS = 32;

    // The magnitude of 0x80000000 comes back as 0x80000000, which is 2^31
    // when treated as unsigned, so no overflow handling is needed.
    function automatic logic [31:0] md_abs(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/md_signfix.sv
// Sign correction of the unsigned iteration result.
//   is_div : 1 = raw holds {remainder, quotient}, 0 = raw holds the product
//   neg_lo : negate the product (multiply) or the quotient (divide)
//   neg_hi : negate the remainder (divide only)
//   raw    : unsigned result from the iteration datapath
//   fixed  : corrected {hi, lo}
module md_signfix (
    input  logic        is_div,
    input  logic        neg_lo,
    input  logic        neg_hi,
    input  logic [63:0] raw,
    output logic [63:0] fixed
);

    // Apply the product negation or the independent quotient/remainder negation.
    always_comb begin
        fixed = raw;
        if (is_div) begin
            fixed[31:0]  = neg_lo ? (32'd0 - raw[31:0])  : raw[31:0];
            fixed[63:32] = neg_hi ? (32'd0 - raw[63:32]) : raw[63:32];
        end else if (neg_lo) begin
            fixed = 64'd0 - raw;
        end else begin
            fixed = raw;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle launch pulse, honoured only while idle
//   md_op      : operation code (md_op_t)
//   a, b       : rs / rt operands
//   busy       : operation in progress
//   done       : one-cycle pulse, hi/lo carry the new result
//   hi, lo     : HI and LO registers
module muldiv_unit
    import md_pkg::*;
#(
    parameter int ITERS = MD_ITERS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state_r, state_nxt_s;
    logic [4:0]  cnt_r;
    logic [63:0] acc_r;      // multiply: {partial product, multiplier}; divide: {remainder, quotient}
    logic [31:0] opnd_r;     // multiplicand or divisor magnitude
    logic        is_div_r, neg_lo_r, neg_hi_r;
    logic        busy_r, done_r;
    logic [31:0] hi_r, lo_r;

    logic        launch_s, mt_hi_s, mt_lo_s;
    logic [63:0] init_acc_s;
    logic [31:0] init_opnd_s;
    logic        init_div_s, init_neg_lo_s, init_neg_hi_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_shift_s;
    logic        div_borrow_s;
    logic [31:0] div_diff_s;
    logic [63:0] step_acc_s;
    logic [63:0] fixed_s;

    // Decode a start request in IDLE into launch/move actions and initial operands.
    always_comb begin
        launch_s      = 1'b0;
        mt_hi_s       = 1'b0;
        mt_lo_s       = 1'b0;
        init_acc_s    = 64'd0;
        init_opnd_s   = 32'd0;
        init_div_s    = 1'b0;
        init_neg_lo_s = 1'b0;
        init_neg_hi_s = 1'b0;
        if (start && (state_r == IDLE)) begin
            case (md_op_t'(md_op))
                MD_MULT: begin
                    launch_s      = 1'b1;
                    init_acc_s    = {32'd0, md_abs(b)};
                    init_opnd_s   = md_abs(a);
                    init_neg_lo_s = a[31] ^ b[31];
                end
                MD_MULTU: begin
                    launch_s    = 1'b1;
                    init_acc_s  = {32'd0, b};
                    init_opnd_s = a;
                end
                MD_DIV: begin
                    launch_s      = 1'b1;
                    init_acc_s    = {32'd0, md_abs(a)};
                    init_opnd_s   = md_abs(b);
                    init_div_s    = 1'b1;
                    // A zero divisor yields an all-ones quotient that must stay unnegated.
                    init_neg_lo_s = (a[31] ^ b[31]) & (b != 32'd0);
                    init_neg_hi_s = a[31];
                end
                MD_DIVU: begin
                    launch_s    = 1'b1;
                    init_acc_s  = {32'd0, a};
                    init_opnd_s = b;
                    init_div_s  = 1'b1;
                end
                MD_MTHI: mt_hi_s = 1'b1;
                MD_MTLO: mt_lo_s = 1'b1;
                default: begin
                    launch_s = 1'b0;
                end
            endcase
        end else begin
            launch_s = 1'b0;
        end
    end

    // One iteration step: shift-add multiply or restoring divide.
    always_comb begin
        mul_sum_s    = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        div_shift_s  = {acc_r[63:32], acc_r[31]};
        div_borrow_s = (div_shift_s < {1'b0, opnd_r});
        // On success the difference is below the divisor, so 32 bits hold it exactly.
        div_diff_s   = div_shift_s[31:0] - opnd_r;
        if (is_div_r) begin
            if (div_borrow_s) begin
                step_acc_s = {div_shift_s[31:0], acc_r[30:0], 1'b0};
            end else begin
                step_acc_s = {div_diff_s, acc_r[30:0], 1'b1};
            end
        end else begin
            step_acc_s = {mul_sum_s, acc_r[31:1]};
        end
    end

    md_signfix u_signfix (
        .is_div (is_div_r),
        .neg_lo (neg_lo_r),
        .neg_hi (neg_hi_r),
        .raw    (acc_r),
        .fixed  (fixed_s)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Controller next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == 5'(ITERS - 1)) begin
                    state_nxt_s = FIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath, HI/LO and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r    <= 5'd0;
            acc_r    <= 64'd0;
            opnd_r   <= 32'd0;
            is_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (launch_s) begin
                        acc_r    <= init_acc_s;
                        opnd_r   <= init_opnd_s;
                        is_div_r <= init_div_s;
                        neg_lo_r <= init_neg_lo_s;
                        neg_hi_r <= init_neg_hi_s;
                        cnt_r    <= 5'd0;
                        busy_r   <= 1'b1;
                    end else if (mt_hi_s) begin
                        hi_r <= a;
                    end else if (mt_lo_s) begin
                        lo_r <= a;
                    end
                end
                RUN: begin
                    acc_r <= step_acc_s;
                    cnt_r <= cnt_r + 5'd1;
                end
                FIN: begin
                    hi_r   <= fixed_s[63:32];
                    lo_r   <= fixed_s[31:0];
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner vectors, randomized
// operations against an arithmetic reference model, MTHI/MTLO handling,
// ignored starts while busy, and reset during an operation.
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // MIPS-level meaning of each operation, from plain integer arithmetic.
    function automatic void ref_model(input logic [2:0] op, input logic [31:0] av,
                                      input logic [31:0] bv,
                                      output logic [31:0] rh, output logic [31:0] rl);
        longint     p;
        logic [63:0] u;
        int         sa, sb;
        sa = av;
        sb = bv;
        rh = 32'd0;
        rl = 32'd0;
        case (op)
            OP_MULT: begin
                p  = longint'(sa) * longint'(sb);
                rh = p[63:32];
                rl = p[31:0];
            end
            OP_MULTU: begin
                u  = {32'd0, av} * {32'd0, bv};
                rh = u[63:32];
                rl = u[31:0];
            end
            OP_DIV: begin
                if (bv == 32'd0) begin
                    rl = 32'hFFFF_FFFF; rh = av;
                end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                    rl = 32'h8000_0000; rh = 32'd0;
                end else begin
                    rl = 32'(sa / sb); rh = 32'(sa % sb);
                end
            end
            OP_DIVU: begin
                if (bv == 32'd0) begin
                    rl = 32'hFFFF_FFFF; rh = av;
                end else begin
                    rl = av / bv; rh = av % bv;
                end
            end
            default: begin
                rh = 32'd0;
                rl = 32'd0;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'd0 - 32'($urandom_range(1, 15));
            default: return $urandom();
        endcase
    endfunction

    // Drive one start (caller sits just after a rising edge) and wait for done.
    // lat counts rising edges after the edge that sampled start.
    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         output int lat, output int busy_cnt, output bit got);
        start = 1'b1; md_op = op; a = av; b = bv;
        lat = -1; busy_cnt = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (hi !== 32'd0)  begin miscompares++; $display("FAIL reset_hi: got %h want 0", hi); end
        vectors++; if (lo !== 32'd0)  begin miscompares++; $display("FAIL reset_lo: got %h want 0", lo); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        // reset must win over a simultaneous MTHI
        start = 1'b1; md_op = OP_MTHI; a = 32'h0000_AAAA;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL reset_wins_hi: got %h want 0", hi); end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_wins_busy: got %b want 0", busy); end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] av, bv, eh, el;
    } vec_t;

    task automatic test_directed();
        vec_t dv[8];
        int lat, bc;
        bit got;
        dv[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        dv[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        dv[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        dv[3] = '{OP_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        dv[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        dv[5] = '{OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
        dv[6] = '{OP_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        dv[7] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        for (int i = 0; i < 8; i++) begin
            issue(dv[i].op, dv[i].av, dv[i].bv, lat, bc, got);
            vectors++; if (!got) begin miscompares++; $display("FAIL dir%0d_timeout: no done within %0d cycles", i, lat); end
            vectors++; if (lat != 33) begin miscompares++; $display("FAIL dir%0d_latency: got %0d want 33", i, lat); end
            vectors++; if (bc != 33)  begin miscompares++; $display("FAIL dir%0d_busy_cycles: got %0d want 33", i, bc); end
            vectors++; if (hi !== dv[i].eh) begin miscompares++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, dv[i].eh); end
            vectors++; if (lo !== dv[i].el) begin miscompares++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, dv[i].el); end
            @(posedge clk); #1;
            vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL dir%0d_done_width: got %b want 0", i, done); end
            exp_hi = dv[i].eh;
            exp_lo = dv[i].el;
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] av, bv, rh, rl;
        int lat, bc;
        bit got;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            av = pick_operand();
            bv = pick_operand();
            if (op <= OP_DIVU) begin
                ref_model(op, av, bv, rh, rl);
                issue(op, av, bv, lat, bc, got);
                vectors++; if (!got || lat != 33) begin miscompares++; $display("FAIL rnd%0d_latency: got %0d want 33 (op %0d)", i, lat, op); end
                vectors++; if (hi !== rh) begin miscompares++; $display("FAIL rnd%0d_hi: op %0d a %h b %h got %h want %h", i, op, av, bv, hi, rh); end
                vectors++; if (lo !== rl) begin miscompares++; $display("FAIL rnd%0d_lo: op %0d a %h b %h got %h want %h", i, op, av, bv, lo, rl); end
                exp_hi = rh;
                exp_lo = rl;
            end else begin
                if (op == OP_MTHI) exp_hi = av;
                if (op == OP_MTLO) exp_lo = av;
                start = 1'b1; md_op = op; a = av; b = bv;
                @(posedge clk); #1;
                start = 1'b0;
                vectors++; if (hi !== exp_hi) begin miscompares++; $display("FAIL rnd%0d_move_hi: op %0d got %h want %h", i, op, hi, exp_hi); end
                vectors++; if (lo !== exp_lo) begin miscompares++; $display("FAIL rnd%0d_move_lo: op %0d got %h want %h", i, op, lo, exp_lo); end
                @(posedge clk); #1;
                vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_move_status: busy %b done %b want 0 0", i, busy, done); end
            end
        end
    endtask

    task automatic test_busy_ignore();
        int c, extra_done, extra_busy;
        bit got;
        start = 1'b1; md_op = OP_MTHI; a = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++; if (hi !== 32'h1234_5678) begin miscompares++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
        vectors++; if (lo !== exp_lo) begin miscompares++; $display("FAIL mthi_lo_kept: got %h want %h", lo, exp_lo); end
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL mthi_status: busy %b done %b want 0 0", busy, done); end
        start = 1'b1; md_op = OP_MULTU; a = 32'd2; b = 32'd3;
        c = -1; got = 1'b0;
        while (!got && c < 100) begin
            @(posedge clk); #1;
            c++;
            start = 1'b0;
            if (done === 1'b1) got = 1'b1;
            else if (c == 5) begin start = 1'b1; md_op = OP_MTLO; a = 32'h0000_DEAD; end
            else if (c == 6) begin
                vectors++; if (lo !== exp_lo) begin miscompares++; $display("FAIL busy_mtlo_ignored: got %h want %h", lo, exp_lo); end
            end
            else if (c == 10) begin start = 1'b1; md_op = OP_MULT; a = 32'd7; b = 32'd7; end
        end
        vectors++; if (!got || c != 33) begin miscompares++; $display("FAIL busy_latency: got %0d want 33", c); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL busy_final_hi: got %h want 0", hi); end
        vectors++; if (lo !== 32'd6) begin miscompares++; $display("FAIL busy_final_lo: got %h want 6", lo); end
        extra_done = 0; extra_busy = 0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra_done++;
            if (busy === 1'b1) extra_busy++;
        end
        vectors++; if (extra_done != 0 || extra_busy != 0) begin miscompares++; $display("FAIL busy_start_ignored: done %0d busy %0d want 0 0", extra_done, extra_busy); end
        exp_hi = 32'd0;
        exp_lo = 32'd6;
    endtask

    task automatic test_reset_midrun();
        int lat, bc, seen;
        bit got;
        start = 1'b1; md_op = OP_MTHI; a = 32'h1111_1111;
        @(posedge clk); #1;
        md_op = OP_MTLO; a = 32'h2222_2222;
        @(posedge clk); #1;
        start = 1'b1; md_op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrun_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrun_busy: got %b want 0", busy); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL midrun_hi: got %h want 0", hi); end
        vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL midrun_lo: got %h want 0", lo); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL midrun_no_done: got %0d active cycles want 0", seen); end
        issue(OP_MULTU, 32'd4, 32'd4, lat, bc, got);
        vectors++; if (!got || lat != 33) begin miscompares++; $display("FAIL post_reset_latency: got %0d want 33", lat); end
        vectors++; if (lo !== 32'd16) begin miscompares++; $display("FAIL post_reset_lo: got %h want 10", lo); end
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL post_reset_hi: got %h want 0", hi); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_random();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
